ame_num_normal_pipe: RTL and testbench

Multi-lane, pipelined successor to the single-lane approximate-magnitude normaliser in the AME datapath. Each lane right-shifts its input by the index of the most-significant set bit of its approximation word. Each lane optionally rounds half-up, applies a sign, and flags zero-approximation cases. The block replaces the single-shot init/done pulse with a full valid/ready stream so it can sit directly between the AME accumulator and downstream quantisation stages under backpressure.

---
 rtl/ame_num_normal_pipe.sv | 145 ++++++++++++++
 tb/tb_ame_num_normal_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_num_normal_pipe.sv
// Multi-lane approximate-magnitude normaliser: shifts each lane right by the MSB index
// of its approximation word, with optional half-up rounding, sign and zero flag.
module ame_num_normal_pipe #(
  parameter int DATA_BITS  = 64,
  parameter int LANES      = 4,
  parameter int SHIFT_BITS = $clog2(DATA_BITS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          s_round_i,
  input  logic [LANES*DATA_BITS-1:0]    s_approx_i,
  input  logic [LANES-1:0]              s_sign_i,
  input  logic [LANES*DATA_BITS-1:0]    s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [LANES*DATA_BITS-1:0]    m_data_o,
  output logic [LANES-1:0]              m_zero_o,
  output logic [LANES*SHIFT_BITS-1:0]   m_shift_o
);

  function automatic logic [SHIFT_BITS-1:0] msb_idx(input logic [DATA_BITS-1:0] a);
    logic [SHIFT_BITS-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BITS; i++)
      if (a[i]) k = SHIFT_BITS'(i);
    return k;
  endfunction

  function automatic logic [DATA_BITS-1:0] round_half_up(input logic [DATA_BITS-1:0] r,
                                                         input logic rbit, input logic en);
    return en ? r + DATA_BITS'(rbit) : r;
  endfunction

  function automatic logic signed [DATA_BITS-1:0] apply_sign(input logic [DATA_BITS-1:0] r,
                                                             input logic neg);
    logic signed [DATA_BITS-1:0] s;
    s = $signed(r);
    return neg ? -s : s;
  endfunction

  logic                  vld_p1, vld_p2, load_p1, load_p2;
  logic                  round_p1;
  logic [SHIFT_BITS-1:0] k_p0    [LANES];
  logic                  zero_p0 [LANES];
  logic                  rbit_p0 [LANES];
  logic [SHIFT_BITS-1:0] k_p1    [LANES];
  logic                  zero_p1 [LANES];
  logic                  rbit_p1 [LANES];
  logic                  sign_p1 [LANES];
  logic [DATA_BITS-1:0]  data_p1 [LANES];
  logic signed [DATA_BITS-1:0] res_p1 [LANES];
  logic signed [DATA_BITS-1:0] data_p2 [LANES];
  logic [SHIFT_BITS-1:0] shift_p2 [LANES];
  logic                  zero_p2  [LANES];

  assign s_ready_o = ~vld_p1 | ~vld_p2 | m_ready_i;
  assign load_p1   = s_valid_i & s_ready_o;
  assign load_p2   = vld_p1 & (~vld_p2 | m_ready_i);
  assign m_valid_o = vld_p2;

  // Stage 0 -> 1: priority encode and capture the bit just below the shift point
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [DATA_BITS-1:0]  a, d;
      logic [SHIFT_BITS-1:0] km1;
      a          = s_approx_i[l*DATA_BITS +: DATA_BITS];
      d          = s_data_i[l*DATA_BITS +: DATA_BITS];
      k_p0[l]    = msb_idx(a);
      zero_p0[l] = ~|a;
      km1        = k_p0[l] - SHIFT_BITS'(1);
      rbit_p0[l] = (k_p0[l] != '0) ? d[km1] : 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      round_p1 <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        k_p1[l]    <= '0;
        zero_p1[l] <= 1'b0;
        rbit_p1[l] <= 1'b0;
        sign_p1[l] <= 1'b0;
        data_p1[l] <= '0;
      end
    end else if (load_p1) begin
      vld_p1   <= 1'b1;
      round_p1 <= s_round_i;
      for (int l = 0; l < LANES; l++) begin
        k_p1[l]    <= k_p0[l];
        zero_p1[l] <= zero_p0[l];
        rbit_p1[l] <= rbit_p0[l];
        sign_p1[l] <= s_sign_i[l];
        data_p1[l] <= s_data_i[l*DATA_BITS +: DATA_BITS];
      end
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 1 -> 2: shift, round, zero override, then negate
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [DATA_BITS-1:0] r;
      r = data_p1[l] >> k_p1[l];
      r = round_half_up(r, rbit_p1[l], round_p1);
      if (zero_p1[l]) r = '0;
      res_p1[l] = apply_sign(r, sign_p1[l]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2 <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        data_p2[l]  <= '0;
        shift_p2[l] <= '0;
        zero_p2[l]  <= 1'b0;
      end
    end else if (load_p2) begin
      vld_p2 <= 1'b1;
      for (int l = 0; l < LANES; l++) begin
        data_p2[l]  <= res_p1[l];
        shift_p2[l] <= k_p1[l];
        zero_p2[l]  <= zero_p1[l];
      end
    end else if (m_ready_i) begin
      vld_p2 <= 1'b0;
    end
  end

  always_comb begin
    m_data_o  = '0;
    m_zero_o  = '0;
    m_shift_o = '0;
    for (int l = 0; l < LANES; l++) begin
      m_data_o[l*DATA_BITS +: DATA_BITS]    = data_p2[l];
      m_zero_o[l]                           = zero_p2[l];
      m_shift_o[l*SHIFT_BITS +: SHIFT_BITS] = shift_p2[l];
    end
  end

endmodule

// File: tb/tb_ame_num_normal_pipe.sv
// Scoreboard bench for ame_num_normal_pipe: directed vectors, backpressure, reset and random beats.
module tb_ame_num_normal_pipe;
  localparam int DB = 64;
  localparam int LN = 4;
  localparam int SB = 6;

  logic clk = 1'b0;
  logic rst_i, s_valid_i, s_ready_o, s_round_i, m_valid_o, m_ready_i;
  logic [LN*DB-1:0] s_approx_i, s_data_i, m_data_o;
  logic [LN-1:0]    s_sign_i, m_zero_o;
  logic [LN*SB-1:0] m_shift_o;

  always #5 clk = ~clk;

  ame_num_normal_pipe #(.DATA_BITS(DB), .LANES(LN), .SHIFT_BITS(SB)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_round_i(s_round_i),
    .s_approx_i(s_approx_i), .s_sign_i(s_sign_i), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_zero_o(m_zero_o), .m_shift_o(m_shift_o)
  );

  typedef struct packed {
    logic [LN*DB-1:0] d;
    logic [LN-1:0]    z;
    logic [LN*SB-1:0] s;
  } beat_t;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    rdy_mode = 0;
  int    pidx = 0;
  bit    rdy_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: half-up rounding via (d >> (k-1)) + 1, halved, in a wider word
  function automatic beat_t model(input logic rnd, input logic [LN*DB-1:0] ap, dt,
                                  input logic [LN-1:0] sg);
    beat_t b;
    b = '0;
    for (int l = 0; l < LN; l++) begin
      logic [DB-1:0] a, d, r;
      logic [DB:0]   t;
      int            k;
      bit            hit;
      a = ap[l*DB +: DB];
      d = dt[l*DB +: DB];
      k = 0;
      hit = 1'b0;
      for (int i = DB-1; i >= 0; i--)
        if (!hit && a[i]) begin k = i; hit = 1'b1; end
      if (!hit) r = '0;
      else if (rnd && k > 0) begin
        t = {1'b0, d >> (k-1)} + 65'd1;
        r = t[DB:1];
      end else r = d >> k;
      if (sg[l]) r = 64'd0 - r;
      b.d[l*DB +: DB] = r;
      b.z[l]          = !hit;
      b.s[l*SB +: SB] = k[SB-1:0];
    end
    return b;
  endfunction

  logic             stall_prev = 1'b0;
  logic [LN*DB-1:0] held_d;
  logic [LN-1:0]    held_z;
  logic [LN*SB-1:0] held_s;

  always @(negedge clk) begin
    if (rst_i) begin
      sb_q.delete();
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {63'd0, (held_d !== m_data_o) || (held_z !== m_zero_o) || (held_s !== m_shift_o)}, 64'd0);
      if (sb_q.size() == 0) chk("idle_valid", {63'd0, m_valid_o}, 64'd0);
      if (sb_q.size() == 2) chk("full_valid", {63'd0, m_valid_o}, 64'd1);
      chk("s_ready", {63'd0, s_ready_o}, {63'd0, !(sb_q.size() == 2 && !m_ready_i)});
      if (m_valid_o && m_ready_i) begin
        if (sb_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          for (int l = 0; l < LN; l++) begin
            chk($sformatf("l%0d_data", l), m_data_o[l*DB +: DB], sb_q[0].d[l*DB +: DB]);
            chk($sformatf("l%0d_zero", l), {63'd0, m_zero_o[l]}, {63'd0, sb_q[0].z[l]});
            chk($sformatf("l%0d_shift", l), {58'd0, m_shift_o[l*SB +: SB]}, {58'd0, sb_q[0].s[l*SB +: SB]});
          end
          void'(sb_q.pop_front());
        end
      end
      if (s_valid_i && s_ready_o) sb_q.push_back(model(s_round_i, s_approx_i, s_data_i, s_sign_i));
      stall_prev <= m_valid_o && !m_ready_i;
      held_d <= m_data_o;
      held_z <= m_zero_o;
      held_s <= m_shift_o;
    end
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready_i = 1'b1;
        1: m_ready_i = 1'b0;
        2: m_ready_i = 1'($urandom_range(0, 1));
        default: begin m_ready_i = rdy_pat[pidx % 8]; pidx++; end
      endcase
    end
  end

  task automatic send(input logic rnd, input logic [LN*DB-1:0] ap, dt, input logic [LN-1:0] sg);
    int   guard;
    logic acc;
    guard = 0;
    s_valid_i = 1'b1; s_round_i = rnd; s_approx_i = ap; s_data_i = dt; s_sign_i = sg;
    do begin
      @(negedge clk); acc = s_ready_o;
      @(posedge clk); #1; guard++;
    end while (!acc && guard < 1000);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    s_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin @(posedge clk); #1; guard++; end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic probe(input string tag, input logic rnd, input logic [LN*DB-1:0] ap, dt,
                       input logic [LN-1:0] sg);
    rdy_mode = 0;
    drain();
    repeat (2) begin @(posedge clk); #1; end
    send(rnd, ap, dt, sg);
    chk({tag, "_lat1"}, {63'd0, m_valid_o}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, {63'd0, m_valid_o}, 64'd1);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;
  logic [LN*DB-1:0] ap, dt;

  initial begin
    rst_i = 1'b1; s_valid_i = 1'b0; s_round_i = 1'b0;
    s_approx_i = '0; s_data_i = '0; s_sign_i = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_data", {63'd0, |m_data_o}, 64'd0);
    chk("rst_zero", {60'd0, m_zero_o}, 64'd0);
    chk("rst_shift", {40'd0, m_shift_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", {63'd0, s_ready_o}, 64'd1);

    ap = {64'h0, 64'h8, 64'h12, 64'h10};
    dt = {64'hFFFF, 64'h1C, 64'h100, 64'h100};
    probe("basic", 1'b0, ap, dt, 4'b1000);
    chk("basic_l0_data", m_data_o[63:0], 64'h10);
    chk("basic_l0_shift", {58'd0, m_shift_o[5:0]}, 64'd4);
    chk("basic_l0_zero", {63'd0, m_zero_o[0]}, 64'd0);
    chk("basic_l1_shift", {58'd0, m_shift_o[11:6]}, 64'd4);
    chk("trunc_l2_data", m_data_o[191:128], 64'h3);
    chk("zero_l3_data", m_data_o[255:192], 64'h0);
    chk("zero_l3_flag", {63'd0, m_zero_o[3]}, 64'd1);

    ap = {TOP, 64'h8, 64'h1, 64'h8};
    dt = {ONES, 64'h1C, 64'h1C, 64'h1C};
    probe("round", 1'b1, ap, dt, 4'b0100);
    chk("round_l0_data", m_data_o[63:0], 64'h4);
    chk("round_k0_l1_data", m_data_o[127:64], 64'h1C);
    chk("round_neg_l2_data", m_data_o[191:128], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("round_top_l3_data", m_data_o[255:192], 64'h2);

    ap = {64'h8, TOP, 64'h12, 64'h0};
    dt = {64'h1C, ONES, 64'h100, 64'hFFFF};
    probe("zero_rnd", 1'b1, ap, dt, 4'b0001);
    chk("zero_rnd_l0_data", m_data_o[63:0], 64'h0);
    chk("zero_rnd_l0_flag", {63'd0, m_zero_o[0]}, 64'd1);
    chk("zero_rnd_l0_shift", {58'd0, m_shift_o[5:0]}, 64'd0);

    ap = {64'h8, 64'h8, 64'h8, TOP};
    dt = {64'h1C, 64'h1C, 64'h1C, ONES};
    probe("top_trunc", 1'b0, ap, dt, 4'b0000);
    chk("top_trunc_l0_data", m_data_o[63:0], 64'h1);
    chk("top_trunc_l1_data", m_data_o[127:64], 64'h3);
    drain();

    // backpressure with a fixed ready pattern
    rdy_mode = 3; pidx = 0;
    for (int b = 0; b < 8; b++) begin
      ap = {64'h1 << b, 64'h80 >> b, 64'h3 << b, 64'h100 << b};
      dt = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 64'h1234_5678 + 64'(b)};
      send(1'(b & 1), ap, dt, 4'(b));
    end
    rdy_mode = 0;
    drain();

    // reset with two beats in flight
    rdy_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    send(1'b0, {4{64'h10}}, {4{64'h100}}, 4'b0000);
    send(1'b1, {4{64'h8}}, {4{64'h1C}}, 4'b1111);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {63'd0, m_valid_o}, 64'd0);
    chk("midrst_data", {63'd0, |m_data_o}, 64'd0);
    chk("midrst_zero", {60'd0, m_zero_o}, 64'd0);
    chk("midrst_shift", {40'd0, m_shift_o}, 64'd0);
    rst_i = 1'b0;
    rdy_mode = 0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {63'd0, m_valid_o}, 64'd0);
    end
    probe("post_rst", 1'b1, {4{64'h8}}, {4{64'h1C}}, 4'b0000);
    chk("post_rst_l0_data", m_data_o[63:0], 64'h4);

    // randomised beats
    rdy_mode = 2;
    for (int n = 0; n < 10000; n++) begin
      for (int l = 0; l < LN; l++) begin
        logic [63:0] a;
        case ($urandom_range(0, 3))
          0: a = 64'h0;
          1: a = 64'h1 << $urandom_range(0, 63);
          2: a = {$urandom, $urandom};
          default: a = {$urandom, $urandom} >> $urandom_range(0, 63);
        endcase
        ap[l*DB +: DB] = a;
        dt[l*DB +: DB] = {$urandom, $urandom};
      end
      send(1'($urandom_range(0, 1)), ap, dt, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
